ecc_sed_checker: RTL and testbench

//  Downstream consumer of ecc_sed_encoder. Accepts single-error-detect codewords {parity, data},

---
 rtl/ecc_sed_checker_if.sv | 35 +++
 rtl/ecc_sed_checker.sv | 112 +++++++++++
 tb/tb_ecc_sed_checker.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ecc_sed_checker_if.sv
// ecc_sed_checker_if
//   Bundles the codeword input handshake and the decoded-word output handshake
//   of the single-error-detect checker.
//   Signals:
//     enc_valid     codeword valid from the encoder
//     enc_ready     checker can accept a codeword this cycle
//     enc_codeword  {parity, data}, even parity
//     dec_valid     output register holds a word
//     dec_ready     downstream accepts the word
//     dec_data      payload bits
//     dec_error     parity mismatch on the word in dec_data
//   Modports:
//     slave   checker view (consumes codewords, produces decoded words)
//     master  environment view (produces codewords, consumes decoded words)
interface ecc_sed_checker_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  enc_valid;
  logic                  enc_ready;
  logic [DATA_WIDTH:0]   enc_codeword;
  logic                  dec_valid;
  logic                  dec_ready;
  logic [DATA_WIDTH-1:0] dec_data;
  logic                  dec_error;

  modport slave (
    input  enc_valid, enc_codeword, dec_ready,
    output enc_ready, dec_valid, dec_data, dec_error
  );

  modport master (
    output enc_valid, enc_codeword, dec_ready,
    input  enc_ready, dec_valid, dec_data, dec_error
  );
endinterface

// File: rtl/ecc_sed_checker.sv
// ecc_sed_checker
//   Checks even parity on {parity, data} codewords, strips the parity bit and
//   forwards the payload plus an error flag through a one-entry registered
//   output stage with valid/ready backpressure. Keeps a saturating parity
//   error counter and a sticky error flag.
//   Ports:
//     clk         rising-edge clock
//     rst         synchronous, active-high reset
//     bus         ecc_sed_checker_if.slave (enc_* input side, dec_* output side)
//     err_count   saturating count of accepted codewords with a parity error
//     err_sticky  set on any accepted parity error until clr_err
//     clr_err     synchronous clear of err_count and err_sticky
//   Build option:
//     ECC_SED_ERR_DROP_EN  when defined, erroneous codewords are accepted and
//                          counted but never forwarded; dec_error is tied to 0.
module ecc_sed_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  ecc_sed_checker_if.slave     bus,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic                 err_sticky,
  input  logic                 clr_err
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [CNT_WIDTH-1:0]  count_reg;
  logic                  sticky_reg;
  logic                  accept;
  logic                  perr;
  logic                  load;

  // Odd total parity across the codeword means a single-bit (odd) error.
  assign perr = ^bus.enc_codeword;

  // Ready depends only on the stage state and dec_ready, never on enc_valid.
  assign bus.enc_ready = (state_reg == EMPTY) | bus.dec_ready;
  assign accept        = bus.enc_valid & bus.enc_ready;

`ifdef ECC_SED_ERR_DROP_EN
  // Bad words are consumed and counted but never occupy the output stage.
  assign load = accept & ~perr;
`else
  assign load = accept;
`endif

  always_comb begin
    state_next = state_reg;
    if (load) begin
      state_next = FULL;
    end else if ((state_reg == FULL) && bus.dec_ready) begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= EMPTY;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        data_reg <= bus.enc_codeword[DATA_WIDTH-1:0];
      end
    end
  end

`ifdef ECC_SED_ERR_DROP_EN
  assign bus.dec_error = 1'b0;
`else
  logic error_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      error_reg <= 1'b0;
    end else if (load) begin
      error_reg <= perr;
    end
  end

  assign bus.dec_error = error_reg;
`endif

  // A new error in the same cycle as clr_err wins: the count restarts at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg  <= '0;
      sticky_reg <= 1'b0;
    end else if (accept && perr) begin
      sticky_reg <= 1'b1;
      if (clr_err) begin
        count_reg <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else if (count_reg != {CNT_WIDTH{1'b1}}) begin
        count_reg <= count_reg + 1'b1;
      end
    end else if (clr_err) begin
      count_reg  <= '0;
      sticky_reg <= 1'b0;
    end
  end

  assign bus.dec_valid = (state_reg == FULL);
  assign bus.dec_data  = data_reg;
  assign err_count     = count_reg;
  assign err_sticky    = sticky_reg;

endmodule

// File: tb/tb_ecc_sed_checker.sv
module tb_ecc_sed_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr_err = 1'b0;
  logic [15:0] err_count;
  logic        err_sticky;

  logic        rst2 = 1'b1;
  logic        clr_err2 = 1'b0;
  logic [1:0]  err_count2;
  logic        err_sticky2;

  int checks = 0;
  int failures = 0;
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  ecc_sed_checker_if #(.DATA_WIDTH(8)) bus ();
  ecc_sed_checker_if #(.DATA_WIDTH(8)) bus2 ();

  ecc_sed_checker #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .err_count  (err_count),
    .err_sticky (err_sticky),
    .clr_err    (clr_err)
  );

  ecc_sed_checker #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut2 (
    .clk        (clk),
    .rst        (rst2),
    .bus        (bus2.slave),
    .err_count  (err_count2),
    .err_sticky (err_sticky2),
    .clr_err    (clr_err2)
  );

  // Record every word handed over downstream by the main instance.
  always @(posedge clk) begin
    if (!rst && bus.dec_valid && bus.dec_ready) rx_q.push_back(bus.dec_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end else begin
      $display("ok   %s observed=%0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [8:0] t2_words[3];
  int         drain;

  initial begin
    t2_words[0] = 9'h0_00;
    t2_words[1] = 9'h1_01;
    t2_words[2] = 9'h0_03;
    bus.enc_valid = 1'b0; bus.enc_codeword = '0; bus.dec_ready = 1'b0;
    bus2.enc_valid = 1'b0; bus2.enc_codeword = '0; bus2.dec_ready = 1'b1;

    // 1. reset
    step(); step();
    check("rst_dec_valid", bus.dec_valid, 0);
    check("rst_dec_data", bus.dec_data, 0);
    check("rst_err_count", err_count, 0);
    check("rst_err_sticky", err_sticky, 0);
    check("rst_enc_ready", bus.enc_ready, 1);
    rst = 1'b0; rst2 = 1'b0;

    // 2. clean words, one cycle latency each
    bus.dec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.enc_valid = 1'b1; bus.enc_codeword = t2_words[i];
      step();
      check($sformatf("t2_valid_%0d", i), bus.dec_valid, 1);
      check($sformatf("t2_data_%0d", i), bus.dec_data, t2_words[i][7:0]);
      check($sformatf("t2_error_%0d", i), bus.dec_error, 0);
    end
    bus.enc_valid = 1'b0;
    step();
    check("t2_drained", bus.dec_valid, 0);
    check("t2_err_count", err_count, 0);

    // 3. single bad word
    bus.enc_valid = 1'b1; bus.enc_codeword = 9'h0_01;
    step();
    bus.enc_valid = 1'b0;
`ifdef ECC_SED_ERR_DROP_EN
    check("t3_valid_dropped", bus.dec_valid, 0);
`else
    check("t3_valid", bus.dec_valid, 1);
    check("t3_data", bus.dec_data, 8'h01);
    check("t3_error", bus.dec_error, 1);
`endif
    check("t3_err_count", err_count, 1);
    check("t3_err_sticky", err_sticky, 1);
    step();

    // 4. backpressure: AA held, 55 waits, both delivered in order
    rx_q.delete();
    bus.dec_ready = 1'b0;
    bus.enc_valid = 1'b1; bus.enc_codeword = 9'h0_AA;
    step();
    bus.enc_codeword = 9'h0_55;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t4_ready_low_%0d", i), bus.enc_ready, 0);
      step();
      check($sformatf("t4_hold_valid_%0d", i), bus.dec_valid, 1);
      check($sformatf("t4_hold_data_%0d", i), bus.dec_data, 8'hAA);
    end
    bus.dec_ready = 1'b1;
    #1;
    check("t4_ready_high", bus.enc_ready, 1);
    step();
    bus.enc_valid = 1'b0;
    check("t4_second_data", bus.dec_data, 8'h55);
    drain = 0;
    while (bus.dec_valid && drain < 10) begin
      step();
      drain++;
    end
    check("t4_drain_timeout", (drain < 10), 1);
    check("t4_rx_count", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      check("t4_rx_first", rx_q[0], 8'hAA);
      check("t4_rx_second", rx_q[1], 8'h55);
    end
    check("t4_err_count", err_count, 1);

    // clear alone on main instance
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("clr_err_count", err_count, 0);
    check("clr_err_sticky", err_sticky, 0);

    // 5. 2-bit counter saturates, clear+error restarts at 1
    for (int i = 0; i < 5; i++) begin
      bus2.enc_valid = 1'b1; bus2.enc_codeword = 9'h0_01;
      step();
    end
    check("t5_saturated", err_count2, 3);
    check("t5_sticky", err_sticky2, 1);
    clr_err2 = 1'b1;
    step();
    check("t5_clr_and_err_count", err_count2, 1);
    check("t5_clr_and_err_sticky", err_sticky2, 1);
    bus2.enc_valid = 1'b0;
    step();
    clr_err2 = 1'b0;
    check("t5_clr_count", err_count2, 0);
    check("t5_clr_sticky", err_sticky2, 0);

    // 6a. back-to-back stream of 10 words
    rx_q.delete();
    for (int i = 0; i < 10; i++) begin
      bus.enc_valid = 1'b1; bus.enc_codeword = 9'h0_FF;
      step();
      check($sformatf("t6_stream_valid_%0d", i), bus.dec_valid, 1);
      check($sformatf("t6_stream_data_%0d", i), bus.dec_data, 8'hFF);
    end
    bus.enc_valid = 1'b0;
    step();
    check("t6_stream_count", rx_q.size(), 10);

    // 6b. reset during the sixth word of a stream, with an error counted first
    bus.enc_valid = 1'b1; bus.enc_codeword = 9'h1_FF;
    step();
    check("t6_pre_err_count", err_count, 1);
    for (int i = 0; i < 10; i++) begin
      bus.enc_valid = 1'b1; bus.enc_codeword = 9'h0_FF;
      if (i == 5) rst = 1'b1;
      step();
      if (i == 5) begin
        check("t6_rst_dec_valid", bus.dec_valid, 0);
        check("t6_rst_dec_data", bus.dec_data, 0);
        check("t6_rst_err_count", err_count, 0);
        check("t6_rst_err_sticky", err_sticky, 0);
        rst = 1'b0;
        bus.enc_valid = 1'b0;
        break;
      end
    end
    step();
    check("t6_after_rst_idle", bus.dec_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
